// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. It keeps at most one instruction
//               memory read outstanding and presents fetched words through
//               a registered IF/ID interface. The stage holds that interface
//               while downstream is stalled. A one-entry buffer catches a
//               response that arrives during a stall. A redirect flushes the
//               stage and drops any in-flight response.
// Revision    : 1.0 - initial release
//
// Ports
//   clk            single clock, rising edge
//   rst            synchronous reset, active low
//   MuxControlEn   downstream stall (IF/ID register holding)
//   ControlHazard  redirect / flush request
//   BranchTarget   redirect address (word aligned internally)
//   IMemReq        one-cycle read request
//   IMemAddr       read address, meaningful while IMemReq = 1
//   IMemValid      read response strobe
//   IMemData       read response data
//   PCDec          registered PC of the presented instruction
//   Instruction    registered instruction word, 0 = bubble
//   FetchValid     registered, 1 = PCDec/Instruction hold a real instruction
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MuxControlEn,
    input  logic        ControlHazard,
    input  logic [31:0] BranchTarget,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemValid,
    input  logic [31:0] IMemData,
    output logic [31:0] PCDec,
    output logic [31:0] Instruction,
    output logic        FetchValid
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,   // issue a read for pc
        S_WAIT = 2'd1,   // read outstanding, response will be used
        S_HOLD = 2'd2,   // response parked in buffer, waiting for stall release
        S_DROP = 2'd3    // read outstanding, response will be discarded
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] buf_pc;
    logic [31:0] buf_instr;

    // Branch targets are forced to word alignment, so the low bits are unused.
    logic        unused_target_bits;
    assign unused_target_bits = ^BranchTarget[1:0];

    // The request is masked while reset is held. This keeps the first
    // request in the first cycle with rst released.
    assign IMemReq  = rst && (state == S_REQ);
    assign IMemAddr = IMemReq ? pc : 32'h0000_0000;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            buf_pc      <= 32'h0000_0000;
            buf_instr   <= 32'h0000_0000;
            PCDec       <= 32'h0000_0000;
            Instruction <= 32'h0000_0000;
            FetchValid  <= 1'b0;
        end else if (ControlHazard) begin
            // Redirect wins over stall and over any response this cycle.
            pc          <= {BranchTarget[31:2], 2'b00};
            PCDec       <= 32'h0000_0000;
            Instruction <= 32'h0000_0000;
            FetchValid  <= 1'b0;
            unique case (state)
                S_REQ:   state <= S_DROP;  // request just left, must swallow it
                S_WAIT:  state <= IMemValid ? S_REQ : S_DROP;
                S_HOLD:  state <= S_REQ;   // buffered word simply abandoned
                S_DROP:  state <= IMemValid ? S_REQ : S_DROP;
                default: state <= S_REQ;
            endcase
        end else begin
            unique case (state)
                S_REQ: begin
                    state <= S_WAIT;
                    if (!MuxControlEn) begin
                        PCDec       <= 32'h0000_0000;
                        Instruction <= 32'h0000_0000;
                        FetchValid  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (IMemValid) begin
                        if (MuxControlEn) begin
                            buf_pc    <= pc;
                            buf_instr <= IMemData;
                            state     <= S_HOLD;
                        end else begin
                            PCDec       <= pc;
                            Instruction <= IMemData;
                            FetchValid  <= 1'b1;
                            pc          <= pc + 32'd4;
                            state       <= S_REQ;
                        end
                    end else if (!MuxControlEn) begin
                        PCDec       <= 32'h0000_0000;
                        Instruction <= 32'h0000_0000;
                        FetchValid  <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!MuxControlEn) begin
                        PCDec       <= buf_pc;
                        Instruction <= buf_instr;
                        FetchValid  <= 1'b1;
                        pc          <= pc + 32'd4;
                        state       <= S_REQ;
                    end
                end
                S_DROP: begin
                    // Outputs are already a bubble from the redirect.
                    if (IMemValid) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 MuxControlEn  input  1  downstream stall; 1 = IF/ID register is holding, fetch outputs must not advance.
REQ-005 ControlHazard  input  1  redirect/flush request from execute.
REQ-006 BranchTarget  input  32  redirect address, valid when ControlHazard=1.
REQ-007 IMemReq  output  1  instruction memory read request, one-cycle pulse.
REQ-008 IMemAddr  output  32  read address, valid when IMemReq=1.
REQ-009 IMemValid  input  1  read response strobe; earliest one cycle after IMemReq.
REQ-010 IMemData  input  32  read data, valid when IMemValid=1.
REQ-011 PCDec  output  32  registered PC of the presented instruction.
REQ-012 Instruction  output  32  registered instruction word; 32'h0 = bubble.
REQ-013 FetchValid  output  1  registered; 1 = PCDec/Instruction hold a real instruction.

Function
REQ-014 States: REQ, WAIT, HOLD, DROP; at most one memory request outstanding.
REQ-015 IMemReq = 1 only in REQ; IMemAddr = PC in that cycle.
REQ-016 REQ: next state WAIT, regardless of MuxControlEn.
REQ-017 WAIT, IMemValid=0: stay WAIT; outputs hold if MuxControlEn=1, otherwise load bubble (PCDec=0, Instruction=0, FetchValid=0).
REQ-018 WAIT, IMemValid=1, MuxControlEn=0: load PCDec=PC, Instruction=IMemData, FetchValid=1; PC <= PC+4; next REQ.
REQ-019 WAIT, IMemValid=1, MuxControlEn=1: capture {PC, IMemData} in one-entry buffer; outputs hold; next HOLD.
REQ-020 HOLD: while MuxControlEn=1, hold outputs and buffer; on MuxControlEn=0 load outputs from buffer with FetchValid=1, PC <= PC+4, next REQ.
REQ-021 DROP: discard the next IMemValid response; then next REQ; outputs stay bubble.
REQ-022 ControlHazard=1 overrides stall and every rule above: PC <= {BranchTarget[31:2], 2'b00}; outputs <= bubble; buffer invalidated.
REQ-023 ControlHazard state transitions: REQ -> DROP (request just issued); WAIT with IMemValid=0 -> DROP; WAIT with IMemValid=1 -> REQ (response discarded); HOLD -> REQ; DROP with IMemValid=0 -> DROP; DROP with IMemValid=1 -> REQ.
REQ-024 PC arithmetic is modulo 2^32; PC+4 from 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-025 Throughput with 1-cycle memory and no stall: one instruction per 2 cycles.
REQ-026 IMemValid in REQ or HOLD is a protocol error; ignored, no state change.

Reset
REQ-027 rst=0 at posedge: PC=RESET_PC, state=REQ, buffer invalid, PCDec=0, Instruction=0, FetchValid=0.
REQ-028 Reset overrides ControlHazard, stall and responses; reset during WAIT/DROP discards any later stale response because of REQ-026 and DROP rules. A stale response arriving after reset while in WAIT is indistinguishable and is memory's responsibility to suppress.
REQ-029 First IMemReq occurs the cycle after rst deasserts, with IMemAddr=RESET_PC.

Verification
REQ-030 Reset, 1-cycle memory returning addr-derived data, no stall -> PCDec sequence 0,4,8 with FetchValid=1 every second cycle, bubbles between.
REQ-031 Response at PC=8 while MuxControlEn=1 for 3 cycles -> outputs unchanged during stall; PCDec=8 presented the cycle after MuxControlEn falls; next IMemAddr=12.
REQ-032 ControlHazard with BranchTarget=32'h0000_0103 in WAIT, response 2 cycles later -> response discarded, outputs bubble, next IMemAddr=32'h0000_0100.
REQ-033 ControlHazard coinciding with IMemValid -> data discarded, next cycle IMemReq=1 with IMemAddr=BranchTarget.
REQ-034 Redirect to 32'hFFFF_FFFC, no stall -> PCDec FFFF_FFFC then 0000_0000.
REQ-035 rst=0 asserted during HOLD with MuxControlEn=1 -> next cycle all outputs 0, then IMemAddr=RESET_PC.
